rr_arb_requester: RTL and testbench
===================================

Name: rr_arb_requester

Overview:
Client-side agent for the shared round-robin arbiter. One instance per client: it buffers client transactions in a small FIFO, drives one request bit into the arbiter, and consumes the arbiter's registered one-hot grant. It pops one entry per granted cycle and places that entry, tagged with its client ID, on the shared output bus. Request generation accounts for the arbiter's one-cycle grant latency, so no grant is wasted.

Parameters:
DW, 32, payload width in bits
DEPTH, 4, FIFO entries; power of two, at least 2
CLIENT_ID, 0, this client's index in the arbiter's req/gnt vectors
IDW, 3, width of the ID tag; equals clog2 of the arbiter's N
CW, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  client offers a transaction
in_ready  out  1  FIFO can accept; equals not-full
in_data  in  DW  client payload
req_o  out  1  request bit to the arbiter, combinational
gnt_i  in  1  this client's bit of the arbiter's registered gnt vector
out_valid  out  1  shared-bus beat valid, registered
out_data  out  DW  shared-bus payload, registered
out_id  out  IDW  CLIENT_ID tag, registered
level  out  clog2(DEPTH)+1  current FIFO occupancy
grant_cnt  out  CW  grants consumed with data
waste_cnt  out  CW  grants received while the FIFO was empty

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, out_valid=0, out_data=0, out_id=0, both counters 0. Consequently req_o=0 and in_ready=1.
- Push: push = in_valid & in_ready. No bypass: an entry pushed in cycle t is first eligible for a request in cycle t+1.
- Pop: pop = gnt_i & (level != 0). It removes the FIFO head at the clock edge.
- Output register: on pop, out_valid<=1, out_data<=head, out_id<=CLIENT_ID. Otherwise out_valid<=0 and out_data/out_id hold their last values. Latency is one clock from the gnt_i cycle to the out_valid cycle. The bus has no backpressure: a grant is a guaranteed slot.
- Request rule: req_o = (level >= 2) | (level == 1 & ~gnt_i).
  - The arbiter registers its grant, so a request raised in cycle t is granted in t+1 at the earliest.
  - Dropping req_o while the last entry is being granted prevents a follow-on grant into an empty FIFO.
- Simultaneous push and pop: level is unchanged; both pointers advance.
- Full with pop and in_valid in the same cycle: in_ready=0 (no same-cycle refill). The push is retried the next cycle.
- Empty with gnt_i=1: no pop, out_valid<=0, waste_cnt increments. This can only arise from an arbiter protocol violation; it must never occur in a correct system.
- grant_cnt increments on every pop. Both counters saturate at all-ones and do not wrap.
- Pointers are clog2(DEPTH) bits and wrap naturally. level is a separate counter, or is derived from pointers carrying one extra bit.
- Reset mid-operation: contents are discarded, req_o drops combinationally, and out_valid clears immediately.

Decomposition:
- Shared package arb_pkg holds:
  - parameter ARB_N (the arbiter width)
  - localparam ARB_IDW = clog2(ARB_N)
  - the typedef for the bus beat: struct of valid, id, data
- One sub-module, arb_sync_fifo (DW, DEPTH), providing push/pop/full/empty/level. The requester adds the request logic, output register and counters around it.

Test Plan:
- Lone client, pair it with a real arbiter (N=8, CLIENT_ID=2); push 3 beats A,B,C back-to-back -> gnt bit 2 is high for exactly 3 consecutive cycles. out_valid pulses 3 times with A,B,C in order, out_id=2, waste_cnt=0, grant_cnt=3.
- Two clients (IDs 2 and 5), 4 beats each, loaded before any grant -> output alternates 2,5,2,5,... with no idle cycles; total 8 beats, each client's payload in order, waste_cnt=0 on both.
- Fill to DEPTH=4 with no grant -> in_ready=0 and level=4. A 5th in_valid is held off; after one grant, in_ready=1 the next cycle and the 5th beat is accepted. No loss or duplication.
- Force gnt_i=1 while level=0 (stubbed arbiter) -> out_valid stays 0, waste_cnt=1, level stays 0.
- level=1 with gnt_i=1 in the same cycle as in_valid=1 -> level stays 1 and the old head is output. req_o is 0 this cycle and 1 the next cycle.
- Assert rst_n=0 mid-stream with level=3 -> req_o=0, out_valid=0 and level=0 immediately. After release, a fresh push is granted and output correctly with counters restarted from 0.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Definitions shared by the round-robin arbiter and its clients.
//               Covers the arbiter width, the ID tag width and the bus beat
//               layout.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Number of clients on the shared arbiter
  parameter int ARB_N = 8;

  // ID tag width needed to name one of ARB_N clients
  localparam int ARB_IDW = $clog2(ARB_N);

  // Payload width of a beat on the shared output bus
  localparam int ARB_DW = 32;

  // One beat on the shared output bus
  typedef struct packed {
    logic               valid;
    logic [ARB_IDW-1:0] id;
    logic [ARB_DW-1:0]  data;
  } bus_beat_t;

endpackage
`default_nettype wire

// File: rtl/arb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_sync_fifo
// Description : Small synchronous FIFO with an occupancy counter. Pushes while
//               full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; entries need no reset because count gates their use
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_requester
// Description : Client-side agent for the shared round-robin arbiter. Buffers
//               client beats, requests with the arbiter's one-cycle grant
//               latency in mind, and puts granted beats on the shared bus
//               tagged with CLIENT_ID.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_requester
  import arb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int CLIENT_ID = 0,
  parameter int IDW       = ARB_IDW,
  parameter int CW        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [IDW-1:0]         out_id,
  output logic [$clog2(DEPTH):0] level,
  output logic [CW-1:0]          grant_cnt,
  output logic [CW-1:0]          waste_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [DW-1:0] head;

  // No same-cycle refill when full: in_ready depends on full only
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = gnt_i & ~empty;

  // A grant already in flight will consume the last entry, so drop the
  // request then to avoid a follow-on grant into an empty FIFO
  assign req_o = (level >= LW'(2)) | ((level == LW'(1)) & ~gnt_i);

  arb_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Shared-bus output register: one beat per granted, non-empty cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= head;
        out_id   <= IDW'(CLIENT_ID);
      end
    end
  end

  // Saturating statistics: used grants and grants that found the FIFO empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      waste_cnt <= '0;
    end else begin
      if (pop && (grant_cnt != '1)) begin
        grant_cnt <= grant_cnt + CW'(1);
      end
      if (gnt_i && empty && (waste_cnt != '1)) begin
        waste_cnt <= waste_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_requester
// Description : Bench for two requester instances (IDs 2 and 5) on an
//               8-client round-robin arbiter model with optional forced grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_requester;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;
  localparam int CW    = 16;
  localparam int LW    = 3;
  localparam int ID0   = 2;
  localparam int ID1   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic           in_valid  [2];
  logic           in_ready  [2];
  logic [DW-1:0]  in_data   [2];
  logic           req       [2];
  logic           gnt       [2];
  logic           out_valid [2];
  logic [DW-1:0]  out_data  [2];
  logic [IDW-1:0] out_id    [2];
  logic [LW-1:0]  level     [2];
  logic [CW-1:0]  grant_cnt [2];
  logic [CW-1:0]  waste_cnt [2];

  rr_arb_requester #(.DW(DW), .DEPTH(DEPTH), .CLIENT_ID(ID0), .IDW(IDW), .CW(CW)) u_c0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .req_o(req[0]), .gnt_i(gnt[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_id(out_id[0]), .level(level[0]),
    .grant_cnt(grant_cnt[0]), .waste_cnt(waste_cnt[0]));

  rr_arb_requester #(.DW(DW), .DEPTH(DEPTH), .CLIENT_ID(ID1), .IDW(IDW), .CW(CW)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .req_o(req[1]), .gnt_i(gnt[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_id(out_id[1]), .level(level[1]),
    .grant_cnt(grant_cnt[1]), .waste_cnt(waste_cnt[1]));

  // Reference model: per-client queue of accepted beats plus expected outputs
  logic [DW-1:0]  mq [2][$];
  logic           e_ov  [2];
  logic [DW-1:0]  e_od  [2];
  logic [IDW-1:0] e_oid [2];
  int             e_g   [2];
  int             e_w   [2];

  // Stimulus controls
  logic           drv_v [2];
  logic [DW-1:0]  drv_d [2];
  logic           forced;
  logic           fg    [2];
  logic           arb_en;
  logic [7:0]     arb_gnt;
  int             lastg;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      e_ov[k]  = 1'b0;
      e_od[k]  = '0;
      e_oid[k] = '0;
      e_g[k]   = 0;
      e_w[k]   = 0;
    end
    arb_gnt = '0;
  endtask

  task automatic cycle();
    logic [7:0] rv;
    logic [7:0] nxt;
    bit         psh [2];
    bit         pp  [2];
    int         lvl;
    int         idx;
    int         pick;
    for (int k = 0; k < 2; k++) begin
      gnt[k]      = forced ? fg[k] : arb_gnt[(k == 0) ? ID0 : ID1];
      in_valid[k] = drv_v[k];
      in_data[k]  = drv_d[k];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      lvl = mq[k].size();
      chk($sformatf("c%0d_req", k), 64'(req[k]),
          64'((lvl >= 2) || (lvl == 1 && !gnt[k])));
      chk($sformatf("c%0d_in_ready", k), 64'(in_ready[k]), 64'(lvl < DEPTH));
      psh[k] = drv_v[k] && (lvl < DEPTH);
      pp[k]  = gnt[k] && (lvl != 0);
    end
    rv = '0;
    rv[ID0] = req[0];
    rv[ID1] = req[1];
    nxt  = '0;
    pick = -1;
    if (arb_en) begin
      for (int off = 1; off <= 8; off++) begin
        idx = (lastg + off) % 8;
        if (rv[idx] && pick < 0) pick = idx;
      end
      if (pick >= 0) begin
        nxt[pick] = 1'b1;
        lastg     = pick;
      end
    end
    @(posedge clk);
    arb_gnt = nxt;
    for (int k = 0; k < 2; k++) begin
      if (pp[k]) begin
        e_ov[k]  = 1'b1;
        e_od[k]  = mq[k].pop_front();
        e_oid[k] = (k == 0) ? IDW'(ID0) : IDW'(ID1);
        if (e_g[k] < 65535) e_g[k]++;
      end else begin
        e_ov[k] = 1'b0;
        if (gnt[k] && e_w[k] < 65535) e_w[k]++;
      end
      if (psh[k]) mq[k].push_back(drv_d[k]);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("c%0d_out_valid", k), 64'(out_valid[k]), 64'(e_ov[k]));
      chk($sformatf("c%0d_out_data", k), 64'(out_data[k]), 64'(e_od[k]));
      chk($sformatf("c%0d_out_id", k), 64'(out_id[k]), 64'(e_oid[k]));
      chk($sformatf("c%0d_level", k), 64'(level[k]), 64'(mq[k].size()));
      chk($sformatf("c%0d_grant_cnt", k), 64'(grant_cnt[k]), 64'(e_g[k]));
      chk($sformatf("c%0d_waste_cnt", k), 64'(waste_cnt[k]), 64'(e_w[k]));
    end
    @(negedge clk);
  endtask

  initial begin
    int g_cnt, g_first, g_last, g_other;
    int b_cnt, b_first, b_last, alt_err, prev_id;

    for (int k = 0; k < 2; k++) begin
      drv_v[k] = 1'b0; drv_d[k] = '0; fg[k] = 1'b0;
      gnt[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0;
    end
    forced = 1'b1; arb_en = 1'b0; lastg = 0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_level", 64'(level[k]), 64'(0));
      chk("rst_out_valid", 64'(out_valid[k]), 64'(0));
      chk("rst_out_data", 64'(out_data[k]), 64'(0));
      chk("rst_out_id", 64'(out_id[k]), 64'(0));
      chk("rst_grant_cnt", 64'(grant_cnt[k]), 64'(0));
      chk("rst_waste_cnt", 64'(waste_cnt[k]), 64'(0));
      chk("rst_in_ready", 64'(in_ready[k]), 64'(1));
      chk("rst_req", 64'(req[k]), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Lone client with a real arbiter: three back-to-back beats
    forced = 1'b0; arb_en = 1'b1;
    g_cnt = 0; g_first = -1; g_last = -1; g_other = 0;
    for (int c = 0; c < 12; c++) begin
      drv_v[0] = (c < 3);
      drv_d[0] = 32'hA000_0000 + 32'(c);
      cycle();
      if (gnt[0]) begin
        g_cnt++;
        if (g_first < 0) g_first = c;
        g_last = c;
      end
      if (gnt[1]) g_other++;
    end
    chk("t1_gnt_count", 64'(g_cnt), 64'(3));
    chk("t1_gnt_consecutive", 64'(g_last - g_first), 64'(2));
    chk("t1_other_gnt", 64'(g_other), 64'(0));
    chk("t1_grant_cnt", 64'(grant_cnt[0]), 64'(3));
    chk("t1_waste_cnt", 64'(waste_cnt[0]), 64'(0));
    chk("t1_out_id", 64'(out_id[0]), 64'(ID0));

    // Two clients preloaded with four beats each, then released together
    arb_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drv_v[0] = 1'b1; drv_d[0] = 32'hB200_0000 + 32'(c);
      drv_v[1] = 1'b1; drv_d[1] = 32'hB500_0000 + 32'(c);
      cycle();
    end
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    arb_en = 1'b1;
    b_cnt = 0; b_first = -1; b_last = -1; alt_err = 0; prev_id = -1;
    for (int c = 0; c < 14; c++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) begin
          b_cnt++;
          if (b_first < 0) b_first = c;
          b_last = c;
          if (int'(out_id[k]) == prev_id) alt_err++;
          prev_id = int'(out_id[k]);
        end
      end
    end
    chk("t2_beats", 64'(b_cnt), 64'(8));
    chk("t2_no_idle_span", 64'(b_last - b_first), 64'(7));
    chk("t2_alternation_errors", 64'(alt_err), 64'(0));
    chk("t2_waste0", 64'(waste_cnt[0]), 64'(0));
    chk("t2_waste1", 64'(waste_cnt[1]), 64'(0));

    // Fill to DEPTH, hold off a fifth beat, free one slot with a single grant
    forced = 1'b1; fg[0] = 1'b0; fg[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drv_v[0] = 1'b1; drv_d[0] = 32'hC000_0000 + 32'(c);
      cycle();
    end
    chk("t3_full_level", 64'(level[0]), 64'(4));
    chk("t3_full_in_ready", 64'(in_ready[0]), 64'(0));
    drv_d[0] = 32'hC000_00E5;
    cycle();
    fg[0] = 1'b1;
    cycle();
    fg[0] = 1'b0;
    chk("t3_ready_after_grant", 64'(in_ready[0]), 64'(1));
    cycle();
    drv_v[0] = 1'b0;
    chk("t3_level_after_refill", 64'(level[0]), 64'(4));
    forced = 1'b0; arb_en = 1'b1;
    repeat (8) cycle();

    // Grant into an empty FIFO
    forced = 1'b1; fg[0] = 1'b1;
    cycle();
    fg[0] = 1'b0;
    chk("t4_waste_cnt", 64'(waste_cnt[0]), 64'(1));
    chk("t4_out_valid", 64'(out_valid[0]), 64'(0));
    chk("t4_level", 64'(level[0]), 64'(0));

    // level=1 with grant and push in the same cycle
    drv_v[0] = 1'b1; drv_d[0] = 32'hD000_0001;
    cycle();
    drv_d[0] = 32'hD000_0002; fg[0] = 1'b1;
    cycle();
    chk("t5_level", 64'(level[0]), 64'(1));
    chk("t5_old_head_out", 64'(out_data[0]), 64'(32'hD000_0001));
    drv_v[0] = 1'b0; fg[0] = 1'b0;
    cycle();
    fg[0] = 1'b1;
    cycle();
    fg[0] = 1'b0;
    cycle();

    // Reset mid-stream with level=3 and a beat on the bus
    for (int c = 0; c < 4; c++) begin
      drv_v[0] = 1'b1; drv_d[0] = 32'hE000_0000 + 32'(c);
      cycle();
    end
    drv_v[0] = 1'b0; fg[0] = 1'b1;
    cycle();
    chk("t6_pre_level", 64'(level[0]), 64'(3));
    chk("t6_pre_out_valid", 64'(out_valid[0]), 64'(1));
    gnt[0] = 1'b0; fg[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 64'(req[0]), 64'(0));
    chk("t6_rst_out_valid", 64'(out_valid[0]), 64'(0));
    chk("t6_rst_level", 64'(level[0]), 64'(0));
    chk("t6_rst_grant_cnt", 64'(grant_cnt[0]), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    forced = 1'b0; arb_en = 1'b1;
    drv_v[0] = 1'b1; drv_d[0] = 32'hF00D_0001;
    cycle();
    drv_v[0] = 1'b0;
    repeat (5) cycle();
    chk("t6_grant_cnt_restart", 64'(grant_cnt[0]), 64'(1));
    chk("t6_waste_cnt_restart", 64'(waste_cnt[0]), 64'(0));

    // Randomised traffic on both clients through the arbiter model
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 2; k++) begin
        drv_v[k] = ($urandom_range(0, 1) == 1);
        drv_d[k] = $urandom;
      end
      cycle();
    end
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    repeat (20) cycle();
    chk("rnd_drained0", 64'(level[0]), 64'(0));
    chk("rnd_drained1", 64'(level[1]), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
